// File: rtl/spi_pkg.sv
// Shared SPI controller definitions: frame layout, register map and FSM state encoding.
package spi_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned BIT_CNT_W  = 5;
   localparam int unsigned PHASE_W    = 8;

   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } spi_frame_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period phase counter: counts 0..HALF_PERIOD-1 while enabled, held at 0 otherwise.
module spi_clk_tick
   import spi_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick_c
);

   logic [PHASE_W-1:0] phase;

   assign tick_c = en && (phase == PHASE_W'(HALF_PERIOD - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)      phase <= '0;
      else if (!en)    phase <= '0;
      else if (tick_c) phase <= '0;
      else             phase <= phase + PHASE_W'(1);
   end

endmodule

// File: rtl/spi_controller.sv
// SPI write controller (16-bit {rw, addr, data} frames, MSB first, SCLK idles low).
// Define SPI_CTRL_READ_EN to add read frames with CIPO capture into rsp_data.
module spi_controller
   import spi_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
`ifdef SPI_CTRL_READ_EN
   input  logic              cmd_rw,
   input  logic              CIPO,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_valid,
`endif
   output logic              busy,
   output logic              done,
   output logic              SCLK,
   output logic              nCS,
   output logic              COPI
);

   spi_state_e              state, state_d;
   logic [FRAME_BITS-1:0]   sreg, sreg_d;
   logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_d;
   logic                    sclk_d, ncs_d, busy_d, done_d, ready_d;
   logic                    tick_c, accept_c, frame_rw_c;
   spi_frame_t              frame_c;

   spi_clk_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (state != ST_IDLE),
      .tick_c (tick_c)
   );

`ifdef SPI_CTRL_READ_EN
   assign frame_rw_c = cmd_rw;
`else
   assign frame_rw_c = 1'b1;
`endif

   assign accept_c = (state == ST_IDLE) && cmd_valid && cmd_ready;
   assign frame_c  = '{rw: frame_rw_c, addr: cmd_addr, data: cmd_data};
   // The shift register MSB is the serial output; it is cleared before GAP so COPI idles low.
   assign COPI     = sreg[FRAME_BITS-1];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:  if (accept_c) state_d = ST_SETUP;
         ST_SETUP: if (tick_c)   state_d = ST_SHIFT;
         ST_SHIFT: if (tick_c && SCLK && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)))
                                 state_d = ST_HOLD;
         ST_HOLD:  if (tick_c)   state_d = ST_GAP;
         ST_GAP:   if (tick_c)   state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sreg_d    = sreg;
      bit_cnt_d = bit_cnt;
      sclk_d    = SCLK;
      ncs_d     = !(state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      busy_d    = (state_d != ST_IDLE);
      ready_d   = (state_d == ST_IDLE);
      done_d    = (state == ST_HOLD) && (state_d == ST_GAP);
      case (state)
         ST_IDLE: if (accept_c) begin
            sreg_d    = frame_c;
            bit_cnt_d = '0;
            sclk_d    = 1'b0;
         end
         ST_SETUP: if (tick_c) sclk_d = 1'b1;
         // Falling edge advances to the next bit, except after the last bit (HOLD keeps bit 0).
         ST_SHIFT: if (tick_c) begin
            sclk_d = !SCLK;
            if (SCLK) begin
               bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
               if (state_d == ST_SHIFT) sreg_d = {sreg[FRAME_BITS-2:0], 1'b0};
            end
         end
         ST_HOLD: if (tick_c) begin
            sreg_d    = '0;
            bit_cnt_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg      <= '0;
         bit_cnt   <= '0;
         SCLK      <= 1'b0;
         nCS       <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         cmd_ready <= 1'b0;
      end else begin
         sreg      <= sreg_d;
         bit_cnt   <= bit_cnt_d;
         SCLK      <= sclk_d;
         nCS       <= ncs_d;
         busy      <= busy_d;
         done      <= done_d;
         cmd_ready <= ready_d;
      end
   end

`ifdef SPI_CTRL_READ_EN
   logic              rw_q, rw_d;
   logic [DATA_W-1:0] rsp_sh, rsp_sh_d, rsp_data_d;
   logic              rsp_valid_d;

   // CIPO is sampled on the last cycle of each SCLK-high phase of data bits 7..0.
   always_comb begin
      rw_d        = rw_q;
      rsp_sh_d    = rsp_sh;
      rsp_data_d  = rsp_data;
      rsp_valid_d = 1'b0;
      if (accept_c) begin
         rw_d     = cmd_rw;
         rsp_sh_d = '0;
      end
      if ((state == ST_SHIFT) && tick_c && SCLK && (bit_cnt >= BIT_CNT_W'(FRAME_BITS - DATA_W)))
         rsp_sh_d = {rsp_sh[DATA_W-2:0], CIPO};
      if (done_d && !rw_q) begin
         rsp_data_d  = rsp_sh;
         rsp_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rw_q      <= 1'b1;
         rsp_sh    <= '0;
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
      end else begin
         rw_q      <= rw_d;
         rsp_sh    <= rsp_sh_d;
         rsp_data  <= rsp_data_d;
         rsp_valid <= rsp_valid_d;
      end
   end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a bus monitor and register-file peripheral model.
module tb_spi_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       busy, done, SCLK, nCS, COPI;
`ifdef SPI_CTRL_READ_EN
   logic       cmd_rw;
   logic       CIPO;
   logic [7:0] rsp_data;
   logic       rsp_valid;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   spi_controller #(.HALF_PERIOD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
`ifdef SPI_CTRL_READ_EN
      .cmd_rw    (cmd_rw),
      .CIPO      (CIPO),
      .rsp_data  (rsp_data),
      .rsp_valid (rsp_valid),
`endif
      .busy      (busy),
      .done      (done),
      .SCLK      (SCLK),
      .nCS       (nCS),
      .COPI      (COPI)
   );

   always #5 clk = ~clk;

   // Bus monitor and peripheral model state
   int          cyc = 0;
   int          mon_edges = 0;
   int          ncs_cnt = 0;
   int          last_ncs_low = 0;
   int          done_cnt = 0;
   int          rsp_pulses = 0;
   int          aborted = 0;
   int          viol = 0;
   int          last_acc_cyc = 0;
   int          last_done_cyc = 0;
   logic [15:0] mon_bits = '0;
   logic [15:0] frames_q[$];
   int          acc_q[$];
   logic [7:0]  periph[0:4];
   logic        prev_sclk = 1'b0, prev_ncs = 1'b1, prev_copi = 1'b0;
   logic        done_rsp_valid = 1'b0;
   logic [7:0]  done_rsp_data = '0;
   logic [7:0]  rd_val = 8'h3C;

   initial for (int i = 0; i < 5; i++) periph[i] = '0;

   always @(negedge clk) begin
      cyc++;
      if (SCLK && !prev_sclk) begin
         mon_bits = {mon_bits[14:0], COPI};
         mon_edges++;
`ifdef SPI_CTRL_READ_EN
         CIPO = (mon_edges >= 9) ? rd_val[16 - mon_edges] : 1'b0;
`endif
      end
      if (!nCS) ncs_cnt++;
      if (nCS && !prev_ncs) begin
         last_ncs_low = ncs_cnt;
         if (mon_edges == 16) begin
            frames_q.push_back(mon_bits);
            if (mon_bits[15] && mon_bits[14:8] <= 7'd4) periph[mon_bits[14:8]] = mon_bits[7:0];
         end else begin
            aborted++;
         end
         ncs_cnt   = 0;
         mon_edges = 0;
         mon_bits  = '0;
      end
      if (SCLK && prev_sclk && COPI !== prev_copi) viol++;
      if (!nCS && !prev_ncs && COPI !== prev_copi && !(prev_sclk && !SCLK)) viol++;
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
`ifdef SPI_CTRL_READ_EN
         done_rsp_valid = rsp_valid;
         done_rsp_data  = rsp_data;
`endif
      end
`ifdef SPI_CTRL_READ_EN
      if (rsp_valid) rsp_pulses++;
`endif
      if (rst_n && cmd_valid && cmd_ready) begin
         last_acc_cyc = cyc;
         acc_q.push_back(cyc);
      end
      prev_sclk = SCLK;
      prev_ncs  = nCS;
      prev_copi = COPI;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offer one command, wait for its accept edge, then scramble the bus.
   task automatic offer(input logic [6:0] addr, input logic [7:0] data, input logic rw);
      int n = 0;
      while (!cmd_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_before_offer", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_data  = data;
`ifdef SPI_CTRL_READ_EN
      cmd_rw    = rw;
`else
      if (rw) ;
`endif
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_addr  = 7'h7F;
      cmd_data  = 8'h00;
   endtask

   task automatic wait_done(input string tag, input int target);
      for (int i = 0; i < 400 && done_cnt < target; i++) @(posedge clk);
      #1;
      check(tag, 64'(done_cnt), 64'(target));
   endtask

   initial begin
      int rises;
      logic last_sclk;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
`ifdef SPI_CTRL_READ_EN
      cmd_rw    = 1'b1;
      CIPO      = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_ncs", 64'(nCS), 64'd1);
      check("rst_sclk", 64'(SCLK), 64'd0);
      check("rst_ready", 64'(cmd_ready), 64'd0);
      check("rst_busy_done_copi", 64'({busy, done, COPI}), 64'd0);
`ifdef SPI_CTRL_READ_EN
      check("rst_rsp", 64'({rsp_valid, rsp_data}), 64'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", 64'(cmd_ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_ncs_sclk", 64'({nCS, SCLK}), 64'b10);

      // Single write 0x04 <- 0xA5
      offer(7'h04, 8'hA5, 1'b1);
      check("busy_after_accept", 64'(busy), 64'd1);
      wait_done("w1_done", 1);
      check("w1_frame", 64'(frames_q[0]), 64'h84A5);
      check("w1_ncs_low", 64'(last_ncs_low), 64'd132);
      check("w1_latency", 64'(last_done_cyc - last_acc_cyc), 64'd133);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("w1_done_count", 64'(done_cnt), 64'd1);

      // Loopback writes into the peripheral register file
      offer(7'h00, 8'hFF, 1'b1); wait_done("lb0_done", 2);
      offer(7'h02, 8'h0F, 1'b1); wait_done("lb2_done", 3);
      offer(7'h04, 8'h80, 1'b1); wait_done("lb4_done", 4);
      check("lb_regs", 64'({periph[0], periph[1], periph[2], periph[3], periph[4]}), 64'hFF000F0080);
      offer(7'h05, 8'h33, 1'b1); wait_done("lb5_done", 5);
      check("lb5_frame", 64'(frames_q[4]), 64'h8533);
      check("lb5_no_change", 64'({periph[0], periph[1], periph[2], periph[3], periph[4]}), 64'hFF000F0080);

      // Back-to-back with cmd_valid held high
      acc_q.delete();
      cmd_valid = 1'b1; cmd_addr = 7'h02; cmd_data = 8'h11;
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 300 && !cmd_ready; n++) begin
            @(posedge clk); #1;
         end
         @(posedge clk); #1;
         case (k)
            0: begin cmd_addr = 7'h03; cmd_data = 8'h22; end
            1: begin cmd_addr = 7'h01; cmd_data = 8'h33; end
            default: cmd_valid = 1'b0;
         endcase
      end
      wait_done("b2b_done", 8);
      repeat (20) @(posedge clk);
      #1;
      check("b2b_frames", 64'(frames_q.size()), 64'd8);
      check("b2b_f0", 64'(frames_q[5]), 64'h8211);
      check("b2b_f1", 64'(frames_q[6]), 64'h8322);
      check("b2b_f2", 64'(frames_q[7]), 64'h8133);
      check("b2b_accepts", 64'(acc_q.size()), 64'd3);
      check("b2b_gap01", 64'(acc_q[1] - acc_q[0]), 64'd137);
      check("b2b_gap12", 64'(acc_q[2] - acc_q[1]), 64'd137);
      check("b2b_regs", 64'({periph[1], periph[2], periph[3]}), 64'h331122);

      // Reset asserted at the 7th SCLK rising edge
      offer(7'h00, 8'h55, 1'b1);
      rises = 0;
      last_sclk = 1'b0;
      for (int n = 0; n < 300 && rises < 7; n++) begin
         if (SCLK && !last_sclk) rises++;
         last_sclk = SCLK;
         if (rises < 7) begin
            @(posedge clk); #1;
         end
      end
      check("abort_rises", 64'(rises), 64'd7);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_ncs_sclk", 64'({nCS, SCLK}), 64'b10);
      check("abort_busy_ready", 64'({busy, cmd_ready}), 64'b00);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_ready", 64'(cmd_ready), 64'd1);
      repeat (30) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt), 64'd8);
      check("abort_count", 64'(aborted), 64'd1);
      check("abort_reg0", 64'(periph[0]), 64'hFF);
      offer(7'h04, 8'h5A, 1'b1);
      wait_done("post_abort_done", 9);
      check("post_abort_frame", 64'(frames_q[8]), 64'h845A);
      check("post_abort_ncs", 64'(last_ncs_low), 64'd132);
      check("post_abort_reg4", 64'(periph[4]), 64'h5A);

`ifdef SPI_CTRL_READ_EN
      check("no_rsp_on_writes", 64'(rsp_pulses), 64'd0);
      offer(7'h01, 8'h00, 1'b0);
      wait_done("rd_done", 10);
      check("rd_frame", 64'(frames_q[9]), 64'h0100);
      check("rd_bit15", 64'(frames_q[9][15]), 64'd0);
      check("rd_valid_at_done", 64'(done_rsp_valid), 64'd1);
      check("rd_data_at_done", 64'(done_rsp_data), 64'h3C);
      repeat (10) @(posedge clk);
      #1;
      check("rd_data_hold", 64'(rsp_data), 64'h3C);
      check("rd_pulses", 64'(rsp_pulses), 64'd1);
      check("rd_reg1_unchanged", 64'(periph[1]), 64'h33);
`endif

      check("copi_stability", 64'(viol), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4, meaning clk cycles per SCLK half-period; legal range 3..255.
REQ-002 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  a command is offered.
REQ-005 SHALL have port cmd_ready  output  1  the controller can accept a command.
REQ-006 SHALL have port cmd_addr  input  7  the target register address.
REQ-007 SHALL have port cmd_data  input  8  the write data.
REQ-008 SHALL have port busy  output  1  a frame is in progress (any state other than IDLE).
REQ-009 SHALL have port done  output  1  a one-cycle pulse marking frame completion.
REQ-010 SHALL have port SCLK  output  1  the serial clock; idles low.
REQ-011 SHALL have port nCS  output  1  the active-low chip select; idles high.
REQ-012 SHALL have port COPI  output  1  the serial data out, MSB first.

Function
REQ-013 SHALL accept a command only on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 only in IDLE.
REQ-014 SHALL capture the frame {rw, cmd_addr, cmd_data} (16 bits) on the accept cycle; rw SHALL be 1 (write) unless REQ-026 applies.
REQ-015 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, with no other transitions except reset.
REQ-016 SETUP SHALL start on the cycle after accept and last HALF_PERIOD cycles, with nCS=0, SCLK=0 and COPI=frame bit 15.
REQ-017 SHIFT SHALL emit 16 bits, each as HALF_PERIOD cycles SCLK=1 followed by HALF_PERIOD cycles SCLK=0.
REQ-018 COPI SHALL change only on the cycle SCLK falls, to the next lower frame bit, and SHALL be stable for the whole SCLK-high phase.
REQ-019 HOLD is the low phase after the 16th falling edge: HALF_PERIOD cycles, nCS=0, COPI holding bit 0.
REQ-020 GAP SHALL last HALF_PERIOD cycles with nCS=1, SCLK=0, COPI=0; done SHALL pulse on the first GAP cycle.
REQ-021 nCS SHALL be low for exactly 33*HALF_PERIOD cycles per frame; accept-to-next-accept SHALL be at least 34*HALF_PERIOD+1 cycles.
REQ-022 cmd_valid asserted while not in IDLE SHALL be ignored, with no queuing; changes on cmd_addr or cmd_data after accept SHALL NOT affect the frame in flight.
REQ-023 The phase counter SHALL count 0..HALF_PERIOD-1 and wrap to 0; the bit counter SHALL be 5 bits and SHALL terminate SHIFT after exactly 16 bits, never wrapping.

Reset
REQ-024 While rst_n=0 at a clk edge, the block SHALL force: state=IDLE, nCS=1, SCLK=0, COPI=0, busy=0, done=0, cmd_ready=0, all counters 0, shift register 0; cmd_ready SHALL go to 1 on the first cycle after reset release.
REQ-025 Reset mid-frame SHALL abort the frame on that edge without a done pulse; no partial-frame completion.

Configuration
REQ-026 With SPI_CTRL_READ_EN defined, the block SHALL add input cmd_rw (1=write, 0=read) driving frame bit 15, input CIPO (1), output rsp_data (8) and output rsp_valid (1).
REQ-027 With SPI_CTRL_READ_EN defined, CIPO SHALL be sampled on the last clk cycle of each SCLK-high phase for frame bits 7..0, shifted MSB first into rsp_data; rsp_valid SHALL pulse together with done for read frames only; rsp_data SHALL hold until the next read completes and SHALL reset to 0.
REQ-028 Without SPI_CTRL_READ_EN, those ports and that logic SHALL be absent and bit 15 SHALL be constant 1.

Structure
REQ-029 Shared package spi_pkg SHALL hold: FRAME_BITS=16; register addresses ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04; the FSM state enum.
REQ-030 A sub-module spi_clk_tick SHALL generate the half-period tick from HALF_PERIOD; the FSM and shift logic SHALL stay in spi_controller.

Verification
REQ-031 Reset then idle: after rst_n release, nCS=1, SCLK=0, cmd_ready=1, busy=0.
REQ-032 Write addr 0x04, data 0xA5, HALF_PERIOD=4: COPI over 16 rising SCLK edges = 1000_0100_1010_0101; nCS low 132 cycles; one done pulse; 16 rising SCLK edges.
REQ-033 Loopback to the team's SPI peripheral: writes of 0xFF to addr 0x00, 0x0F to 0x02, and 0x80 to 0x04 make the corresponding peripheral registers read 0xFF/0x0F/0x80; a write to addr 0x05 changes nothing.
REQ-034 cmd_valid held high for 3 commands back-to-back: exactly 3 frames, 3 done pulses, each frame carrying its own data, no command dropped or duplicated.
REQ-035 rst_n low at the 7th SCLK rising edge: next cycle nCS=1, SCLK=0, no done pulse; the following command completes normally.
REQ-036 With SPI_CTRL_READ_EN defined: read addr 0x01 with CIPO driven to 0x3C on bits 7..0 gives rsp_valid=1 and rsp_data=0x3C in the done cycle, and COPI bit 15 = 0.
